// File: rtl/alarme_relogio_if.sv
// Signal bundle between the Relogio time source / button block
// and the alarm controller.
interface alarme_relogio_if;
  logic       tick_1hz;
  logic [3:0] hora_dez;
  logic [3:0] hora_unid;
  logic [3:0] min_dez;
  logic [3:0] min_unid;
  logic [3:0] seg_dez;
  logic [3:0] seg_unid;
  logic       en_alarme;
  logic       btn_modo;
  logic       btn_inc_hora;
  logic       btn_inc_min;
  logic       btn_parar;
  logic       btn_soneca;
  logic [3:0] al_hora_dez;
  logic [3:0] al_hora_unid;
  logic [3:0] al_min_dez;
  logic [3:0] al_min_unid;
  logic       buzzer;
  logic       tocando;
  logic       ajustando;

  modport master (
    output tick_1hz, hora_dez, hora_unid,
    output min_dez, min_unid, seg_dez, seg_unid,
    output en_alarme, btn_modo, btn_inc_hora,
    output btn_inc_min, btn_parar, btn_soneca,
    input  al_hora_dez, al_hora_unid,
    input  al_min_dez, al_min_unid,
    input  buzzer, tocando, ajustando
  );

  modport slave (
    input  tick_1hz, hora_dez, hora_unid,
    input  min_dez, min_unid, seg_dez, seg_unid,
    input  en_alarme, btn_modo, btn_inc_hora,
    input  btn_inc_min, btn_parar, btn_soneca,
    output al_hora_dez, al_hora_unid,
    output al_min_dez, al_min_unid,
    output buzzer, tocando, ajustando
  );
endinterface

// File: rtl/alarme_relogio.sv
// Alarm controller fed by the Relogio BCD counters:
// alarm setting, ringing with timeout, snooze and disarm.
module alarme_relogio #(
  parameter int RING_SECONDS = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input logic          clock,
  input logic          reset,
  alarme_relogio_if.slave io
);

  typedef enum logic [1:0] {
    OCIOSO,
    AJUSTE,
    TOCANDO,
    SONECA
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_SECONDS);
  localparam logic [7:0] SNZ      = 8'(SNOOZE_MIN);

  state_t      state, state_nx;
  logic        tick_d;
  logic [15:0] al, al_nx;
  logic [15:0] snz, snz_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [7:0]  cnt_inc;
  logic        buzzer, buzzer_nx;
  logic        tocando, ajustando;
  logic [15:0] now;
  logic        sec_zero;
  logic        hit_al, hit_snz;

  function automatic logic [7:0] inc_h(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23)
      r = 8'h00;
    else if (h[3:0] == 4'd9)
      r = {h[7:4] + 4'd1, 4'd0};
    else
      r = {h[7:4], h[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] inc_m(input logic [7:0] m);
    logic [7:0] r;
    if (m[3:0] == 4'd9)
      r = {(m[7:4] == 4'd5) ? 4'd0 : m[7:4] + 4'd1, 4'd0};
    else
      r = {m[7:4], m[3:0] + 4'd1};
    return r;
  endfunction

  // Binary detour keeps the carry/wrap logic simple.
  function automatic logic [15:0] add_snz(input logic [15:0] t);
    logic [7:0] m, h;
    m = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + SNZ;
    h = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
    if (m >= 8'd60) begin
      m = m - 8'd60;
      h = h + 8'd1;
    end
    if (h >= 8'd24)
      h = h - 8'd24;
    return {4'(h / 8'd10), 4'(h % 8'd10),
            4'(m / 8'd10), 4'(m % 8'd10)};
  endfunction

  assign now = {io.hora_dez, io.hora_unid,
                io.min_dez, io.min_unid};
  assign sec_zero = (io.seg_dez == 4'd0) &&
                    (io.seg_unid == 4'd0);
  assign hit_al  = tick_d && io.en_alarme &&
                   sec_zero && (now == al);
  assign hit_snz = tick_d && io.en_alarme &&
                   sec_zero && (now == snz);
  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    state_nx  = state;
    al_nx     = al;
    snz_nx    = snz;
    cnt_nx    = cnt;
    buzzer_nx = 1'b0;
    unique case (state)
      OCIOSO: begin
        if (io.btn_modo) begin
          state_nx = AJUSTE;
        end else if (hit_al) begin
          state_nx  = TOCANDO;
          cnt_nx    = 8'd0;
          buzzer_nx = 1'b1;
        end
      end
      AJUSTE: begin
        if (io.btn_inc_hora)
          al_nx[15:8] = inc_h(al[15:8]);
        if (io.btn_inc_min)
          al_nx[7:0] = inc_m(al[7:0]);
        if (io.btn_modo)
          state_nx = OCIOSO;
      end
      TOCANDO: begin
        buzzer_nx = buzzer;
        if (!io.en_alarme || io.btn_parar) begin
          state_nx  = OCIOSO;
          buzzer_nx = 1'b0;
        end else if (io.btn_soneca) begin
          state_nx  = SONECA;
          snz_nx    = add_snz(now);
          buzzer_nx = 1'b0;
        end else if (tick_d) begin
          cnt_nx = cnt_inc;
          if (cnt_inc == RING_LIM) begin
            state_nx  = OCIOSO;
            buzzer_nx = 1'b0;
          end else begin
            buzzer_nx = ~buzzer;
          end
        end
      end
      SONECA: begin
        if (!io.en_alarme || io.btn_parar) begin
          state_nx = OCIOSO;
        end else if (hit_snz) begin
          state_nx  = TOCANDO;
          cnt_nx    = 8'd0;
          buzzer_nx = 1'b1;
        end
      end
      default: state_nx = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OCIOSO;
      tick_d    <= 1'b0;
      al        <= 16'h0600;
      snz       <= 16'h0000;
      cnt       <= 8'd0;
      buzzer    <= 1'b0;
      tocando   <= 1'b0;
      ajustando <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_d    <= io.tick_1hz;
      al        <= al_nx;
      snz       <= snz_nx;
      cnt       <= cnt_nx;
      buzzer    <= buzzer_nx;
      tocando   <= (state_nx == TOCANDO);
      ajustando <= (state_nx == AJUSTE);
    end
  end

  assign io.al_hora_dez  = al[15:12];
  assign io.al_hora_unid = al[11:8];
  assign io.al_min_dez   = al[7:4];
  assign io.al_min_unid  = al[3:0];
  assign io.buzzer       = buzzer;
  assign io.tocando      = tocando;
  assign io.ajustando    = ajustando;

endmodule

// File: tb/tb_alarme_relogio.sv
// Directed bench for alarme_relogio with an
// expected-value queue checked at each sample point.
module tb_alarme_relogio;

  logic clock;
  logic reset;

  alarme_relogio_if io();

  alarme_relogio #(
    .RING_SECONDS(60),
    .SNOOZE_MIN(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(io)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  localparam logic [4:0] B_MODO = 5'b10000;
  localparam logic [4:0] B_HORA = 5'b01000;
  localparam logic [4:0] B_MIN  = 5'b00100;
  localparam logic [4:0] B_PAR  = 5'b00010;
  localparam logic [4:0] B_SON  = 5'b00001;

  typedef struct {
    string       tag;
    logic [18:0] exp;
    logic [18:0] mask;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int m_h;
  int m_m;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [18:0] obs();
    return {io.al_hora_dez, io.al_hora_unid,
            io.al_min_dez, io.al_min_unid,
            io.buzzer, io.tocando, io.ajustando};
  endfunction

  task automatic exp_full(input string tag,
                          input int h, input int m,
                          input logic b, input logic t,
                          input logic a);
    exp_t e;
    e.tag  = tag;
    e.exp  = {bcd(h), bcd(m), b, t, a};
    e.mask = '1;
    sb.push_back(e);
  endtask

  task automatic exp_flags(input string tag,
                           input logic b, input logic t,
                           input logic a);
    exp_t e;
    e.tag  = tag;
    e.exp  = {16'h0, b, t, a};
    e.mask = 19'h7;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [18:0] o;
    e = sb.pop_front();
    o = obs() & e.mask;
    n_checks++;
    assert (o === (e.exp & e.mask)) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h",
             e.tag, o, e.exp & e.mask);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_time(input int h, input int m,
                          input int s);
    io.hora_dez  = 4'(h / 10);
    io.hora_unid = 4'(h % 10);
    io.min_dez   = 4'(m / 10);
    io.min_unid  = 4'(m % 10);
    io.seg_dez   = 4'(s / 10);
    io.seg_unid  = 4'(s % 10);
  endtask

  task automatic tick(input int h, input int m,
                      input int s);
    set_time(h, m, s);
    io.tick_1hz = 1'b1;
    cyc();
    io.tick_1hz = 1'b0;
  endtask

  task automatic press(input logic [4:0] b);
    {io.btn_modo, io.btn_inc_hora, io.btn_inc_min,
     io.btn_parar, io.btn_soneca} = b;
    cyc();
    {io.btn_modo, io.btn_inc_hora, io.btn_inc_min,
     io.btn_parar, io.btn_soneca} = 5'b0;
  endtask

  task automatic ring_at(input string tag, input int h,
                         input int m);
    tick(h, m, 0);
    exp_flags(tag, 1'b1, 1'b1, 1'b0);
    cyc();
    check();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    io.tick_1hz = 1'b0;
    io.en_alarme = 1'b0;
    {io.btn_modo, io.btn_inc_hora, io.btn_inc_min,
     io.btn_parar, io.btn_soneca} = 5'b0;
    set_time(0, 0, 0);
    #5;
    exp_full("reset_init", 6, 0, 1'b0, 1'b0, 1'b0);
    check();
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // alarm setting
    m_h = 6;
    m_m = 0;
    exp_full("modo_enter", m_h, m_m, 1'b0, 1'b0, 1'b1);
    press(B_MODO);
    check();
    for (int i = 0; i < 20; i++) begin
      press(B_HORA);
      m_h = (m_h + 1) % 24;
    end
    exp_full("hora_wrap", m_h, m_m, 1'b0, 1'b0, 1'b1);
    check();
    for (int i = 0; i < 61; i++) begin
      press(B_MIN);
      m_m = (m_m + 1) % 60;
    end
    exp_full("min_wrap", m_h, m_m, 1'b0, 1'b0, 1'b1);
    check();
    press(B_HORA | B_MIN);
    m_h = (m_h + 1) % 24;
    m_m = (m_m + 1) % 60;
    exp_full("both_inc", m_h, m_m, 1'b0, 1'b0, 1'b1);
    check();
    press(B_MODO);
    exp_full("modo_exit", m_h, m_m, 1'b0, 1'b0, 1'b0);
    check();

    // asynchronous reset mid-simulation
    #3;
    reset = 1'b1;
    #1;
    exp_full("reset_async", 6, 0, 1'b0, 1'b0, 1'b0);
    check();
    cyc();
    reset = 1'b0;
    m_h = 6;
    m_m = 0;

    // ring and timeout
    io.en_alarme = 1'b1;
    tick(5, 59, 59);
    exp_flags("no_ring_5959", 1'b0, 1'b0, 1'b0);
    cyc();
    check();
    tick(6, 0, 0);
    exp_flags("ring_lat1", 1'b0, 1'b0, 1'b0);
    check();
    exp_full("ring_start", 6, 0, 1'b1, 1'b1, 1'b0);
    cyc();
    check();
    for (int k = 1; k <= 60; k++) begin
      tick(6, k / 60, k % 60);
      exp_flags($sformatf("ring_k%0d", k),
                (k % 2 == 0) && (k < 60), k < 60, 1'b0);
      cyc();
      check();
    end

    // snooze across midnight
    press(B_MODO);
    for (int i = 0; i < 17; i++) begin
      press(B_HORA);
      m_h = (m_h + 1) % 24;
    end
    for (int i = 0; i < 58; i++) begin
      press(B_MIN);
      m_m = (m_m + 1) % 60;
    end
    press(B_MODO);
    exp_full("al_2358", m_h, m_m, 1'b0, 1'b0, 1'b0);
    check();
    ring_at("ring_2358", m_h, m_m);
    press(B_SON);
    exp_flags("soneca_quiet", 1'b0, 1'b0, 1'b0);
    check();
    tick(0, 2, 59);
    exp_flags("snz_0259", 1'b0, 1'b0, 1'b0);
    cyc();
    check();
    tick(0, 3, 0);
    exp_flags("snz_0300", 1'b1, 1'b1, 1'b0);
    cyc();
    check();
    press(B_PAR);
    exp_flags("parar", 1'b0, 1'b0, 1'b0);
    check();

    // stop and snooze together
    ring_at("ring_coll", m_h, m_m);
    press(B_PAR | B_SON);
    exp_flags("coll_stop", 1'b0, 1'b0, 1'b0);
    check();
    tick(0, 3, 0);
    exp_flags("coll_no_snz", 1'b0, 1'b0, 1'b0);
    cyc();
    check();

    // disarm
    io.en_alarme = 1'b0;
    tick(m_h, m_m, 0);
    exp_flags("disarm_no_ring", 1'b0, 1'b0, 1'b0);
    cyc();
    check();
    io.en_alarme = 1'b1;
    ring_at("ring_dis", m_h, m_m);
    press(B_SON);
    io.en_alarme = 1'b0;
    cyc();
    io.en_alarme = 1'b1;
    tick(0, 3, 0);
    exp_flags("dis_snz_cancel", 1'b0, 1'b0, 1'b0);
    cyc();
    check();
    ring_at("ring_en", m_h, m_m);
    io.en_alarme = 1'b0;
    cyc();
    exp_flags("dis_ringing", 1'b0, 1'b0, 1'b0);
    check();
    io.en_alarme = 1'b1;

    // reset while ringing
    ring_at("ring_rst", m_h, m_m);
    #3;
    reset = 1'b1;
    #1;
    exp_full("reset_ring", 6, 0, 1'b0, 1'b0, 1'b0);
    check();
    cyc();
    reset = 1'b0;
    cyc();
    exp_full("after_reset", 6, 0, 1'b0, 1'b0, 1'b0);
    check();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
